// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the multi-precision subtract sequencer
//
// Purpose : state enum, default limb width and the result flag bundle.
// Contents: state_e (IDLE/RUN/DONE), ALU_WIDTH, flags_t {bout, z, n, v}.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic bout;
        logic z;
        logic n;
        logic v;
    } flags_t;

endpackage

// File: rtl/limb_sub.sv
// rtl/limb_sub.sv - combinational single-limb subtract with borrow in/out and zero detect
//
// Purpose: diff = a - b - bin modulo 2^WIDTH.
// Ports  : a_i, b_i (WIDTH) operands; bin_i borrow in;
//          diff_o (WIDTH) difference; bout_o borrow out; zero_o diff is zero.
module limb_sub
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o,
    output logic             zero_o
);

    logic [WIDTH:0] t;

    // Widening by one bit captures the borrow as the top bit of the result.
    assign t      = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, bin_i};
    assign diff_o = t[WIDTH-1:0];
    assign bout_o = t[WIDTH];
    assign zero_o = (t[WIDTH-1:0] == '0);

endmodule

// File: rtl/mp_sub_seq.sv
// rtl/mp_sub_seq.sv - multi-precision subtract sequencer, one limb per beat, LS limb first
//
// Purpose: chains borrow across LIMBS limbs of WIDTH bits, emits each difference
//          limb and final Bout/Z/N/V flags for the full-width result.
// Ports  : clk, rst (async active-high); start, Bin (sampled in IDLE);
//          limb_valid/limb_ready handshake with A, B limbs;
//          Diff/diff_valid per-limb result; busy (RUN), done (one-cycle pulse);
//          Bout, Z, N, V full-width flags, held until the next final beat.
module mp_sub_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int LIMBS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             Bin,
    input  logic             limb_valid,
    output logic             limb_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Diff,
    output logic             diff_valid,
    output logic             busy,
    output logic             done,
    output logic             Bout,
    output logic             Z,
    output logic             N,
    output logic             V
);

    localparam int CW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(LIMBS - 1);

    state_e           state_q, state_d;
    logic             borrow_q, borrow_d;
    logic             zacc_q, zacc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             diff_valid_q, diff_valid_d;
    flags_t           flags_q, flags_d;

    logic [WIDTH-1:0] sub_diff;
    logic             sub_bout;
    logic             sub_zero;
    logic             accept;
    logic             last_beat;

    limb_sub #(.WIDTH(WIDTH)) u_limb_sub (
        .a_i    (A),
        .b_i    (B),
        .bin_i  (borrow_q),
        .diff_o (sub_diff),
        .bout_o (sub_bout),
        .zero_o (sub_zero)
    );

    assign accept    = (state_q == RUN) && limb_valid;
    assign last_beat = accept && (cnt_q == LAST_CNT);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)     state_d = RUN;
            RUN:     if (last_beat) state_d = DONE;
            DONE:                   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        limb_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            RUN: begin
                limb_ready = 1'b1;
                busy       = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: borrow chain, zero accumulator, limb counter, flags
    always_comb begin
        borrow_d     = borrow_q;
        zacc_d       = zacc_q;
        cnt_d        = cnt_q;
        diff_d       = diff_q;
        diff_valid_d = 1'b0;
        flags_d      = flags_q;

        if (state_q == IDLE && start) begin
            borrow_d = Bin;
            zacc_d   = 1'b1;
            cnt_d    = '0;
        end

        if (accept) begin
            diff_d       = sub_diff;
            diff_valid_d = 1'b1;
            borrow_d     = sub_bout;
            zacc_d       = zacc_q & sub_zero;
            // The counter is never advanced past the last beat, so it cannot wrap mid-op.
            if (!last_beat) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                flags_d.bout = sub_bout;
                flags_d.z    = zacc_q & sub_zero;
                flags_d.n    = sub_diff[WIDTH-1];
                // Signed overflow: operand signs differ and result sign differs from A.
                flags_d.v    = (A[WIDTH-1] != B[WIDTH-1]) && (sub_diff[WIDTH-1] != A[WIDTH-1]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            borrow_q     <= 1'b0;
            zacc_q       <= 1'b0;
            cnt_q        <= '0;
            diff_q       <= '0;
            diff_valid_q <= 1'b0;
            flags_q      <= '0;
        end else begin
            borrow_q     <= borrow_d;
            zacc_q       <= zacc_d;
            cnt_q        <= cnt_d;
            diff_q       <= diff_d;
            diff_valid_q <= diff_valid_d;
            flags_q      <= flags_d;
        end
    end

    assign Diff       = diff_q;
    assign diff_valid = diff_valid_q;
    assign Bout       = flags_q.bout;
    assign Z          = flags_q.z;
    assign N          = flags_q.n;
    assign V          = flags_q.v;

endmodule

// File: tb/tb_mp_sub_seq.sv
// tb/tb_mp_sub_seq.sv - self-checking bench for mp_sub_seq (WIDTH=32, LIMBS=2)
module tb_mp_sub_seq;

    localparam int W = 32;
    localparam int L = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         Bin;
    logic         limb_valid;
    logic         limb_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Diff;
    logic         diff_valid;
    logic         busy;
    logic         done;
    logic         Bout;
    logic         Z;
    logic         N;
    logic         V;

    mp_sub_seq #(.WIDTH(W), .LIMBS(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .Bin        (Bin),
        .limb_valid (limb_valid),
        .limb_ready (limb_ready),
        .A          (A),
        .B          (B),
        .Diff       (Diff),
        .diff_valid (diff_valid),
        .busy       (busy),
        .done       (done),
        .Bout       (Bout),
        .Z          (Z),
        .N          (N),
        .V          (V)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        bin;
        int          stall;
        bit          poke;
        bit          overlap;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [3:0]  fl;   // {Bout, Z, N, V}
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_q[$];
    int          ndone;
    logic [3:0]  fl_seen;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (diff_valid) got_q.push_back(Diff);
        if (done) begin
            ndone++;
            fl_seen = {Bout, Z, N, V};
        end
    endtask

    // Full-width reference: one wide subtraction, flags read off the wide result.
    function automatic vec_t model(input logic [63:0] a, input logic [63:0] b, input logic bin);
        vec_t        v;
        logic [64:0] t;
        t         = {1'b0, a} - {1'b0, b} - {64'd0, bin};
        v.a       = a;
        v.b       = b;
        v.bin     = bin;
        v.stall   = 0;
        v.poke    = 0;
        v.overlap = 0;
        v.d0      = t[31:0];
        v.d1      = t[63:32];
        v.fl      = {t[64], t[63:0] == 64'd0, t[63], (a[63] != b[63]) && (t[63] != a[63])};
        return v;
    endfunction

    task automatic run_op(input string nm, input vec_t v);
        got_q.delete();
        ndone   = 0;
        fl_seen = 4'h0;
        start      = 1'b1;
        Bin        = v.bin;
        limb_valid = v.overlap;
        A          = v.a[31:0];
        B          = v.b[31:0];
        step();
        start = 1'b0;
        Bin   = 1'b0;
        for (int i = 0; i < L; i++) begin
            limb_valid = 1'b1;
            A = v.a[i*32 +: 32];
            B = v.b[i*32 +: 32];
            step();
            limb_valid = 1'b0;
            A = $urandom;
            B = $urandom;
            if (i < L - 1) begin
                for (int s = 0; s < v.stall; s++) begin
                    start = v.poke;
                    Bin   = 1'b1;
                    step();
                    start = 1'b0;
                    Bin   = 1'b0;
                end
            end
        end
        for (int k = 0; k < 4 && ndone == 0; k++) step();
        step();
        step();
        chk({nm, "_ndiff"}, got_q.size(), L);
        chk({nm, "_d0"}, got_q.size() > 0 ? got_q[0] : 32'hxxxx_xxxx, v.d0);
        chk({nm, "_d1"}, got_q.size() > 1 ? got_q[1] : 32'hxxxx_xxxx, v.d1);
        chk({nm, "_ndone"}, ndone, 1);
        chk({nm, "_flags"}, fl_seen, v.fl);
        chk({nm, "_hold"}, {busy, done, Bout, Z, N, V}, {2'b00, v.fl});
    endtask

    vec_t tbl[6];
    vec_t rv;
    logic [63:0] ra, rb;

    initial begin
        rst = 1'b1; start = 1'b0; Bin = 1'b0; limb_valid = 1'b0; A = '0; B = '0;
        tbl[0] = '{64'h00000001_00000000, 64'h00000000_00000001, 1'b0, 0, 0, 0, 32'hFFFFFFFF, 32'h00000000, 4'b0000};
        tbl[1] = '{64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 1'b0, 0, 0, 0, 32'h00000000, 32'h00000000, 4'b0100};
        tbl[2] = '{64'h00000000_00000002, 64'h00000000_00000002, 1'b1, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1010};
        tbl[3] = '{64'h80000000_00000000, 64'h00000000_00000001, 1'b0, 0, 0, 0, 32'hFFFFFFFF, 32'h7FFFFFFF, 4'b0001};
        tbl[4] = '{64'h00000001_00000000, 64'h00000000_00000001, 1'b0, 3, 1, 0, 32'hFFFFFFFF, 32'h00000000, 4'b0000};
        tbl[5] = '{64'h00000000_00000005, 64'h00000000_00000003, 1'b1, 1, 0, 1, 32'h00000001, 32'h00000000, 4'b0000};

        step();
        step();
        chk("reset_outs", {Diff, diff_valid, busy, done, limb_ready, Bout, Z, N, V}, 40'd0);
        rst = 1'b0;
        limb_valid = 1'b1;
        step();
        chk("idle_ignores_valid", {diff_valid, busy, limb_ready}, 3'b000);
        limb_valid = 1'b0;

        for (int i = 0; i < 6; i++) run_op($sformatf("vec%0d", i), tbl[i]);

        // Reset in the middle of an operation.
        start = 1'b1; step(); start = 1'b0;
        limb_valid = 1'b1; A = 32'h1; B = 32'h0; step(); limb_valid = 1'b0;
        chk("pre_rst_diff_valid", diff_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {Diff, diff_valid, busy, done, limb_ready, Bout, Z, N, V}, 40'd0);
        step();
        rst = 1'b0;
        ndone = 0;
        got_q.delete();
        limb_valid = 1'b1;
        for (int k = 0; k < 4; k++) step();
        limb_valid = 1'b0;
        chk("post_rst_no_done", ndone, 0);
        chk("post_rst_no_diff", got_q.size(), 0);
        run_op("after_rst", tbl[1]);

        for (int i = 0; i < 24; i++) begin
            ra = {$urandom, $urandom};
            rb = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) ra[63] = ~rb[63];
            rv = model(ra, rb, 1'($urandom_range(0, 1)));
            rv.stall   = $urandom_range(0, 2);
            rv.poke    = 1'($urandom_range(0, 1));
            rv.overlap = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", i), rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
